// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: round count, controller state encoding, S-box and
// the round transforms used by the datapath.
package sm4_pkg;

    localparam int NUM_ROUNDS = 32;

    // Controller states, kept as plain constants for legacy compatibility
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // SM4 S-box, entry 0 first
    localparam logic [0:255][7:0] SBOX = {
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    // Non-linear byte substitution tau
    function automatic logic [31:0] sm4_tau(input logic [31:0] a);
        return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
    endfunction

    // Linear diffusion L: B ^ B<<<2 ^ B<<<10 ^ B<<<18 ^ B<<<24
    function automatic logic [31:0] sm4_l(input logic [31:0] b);
        return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
                 ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
    endfunction

endpackage

// File: rtl/one_round_for_encdec.sv
// Combinational SM4 round shared by encryption and decryption; direction is
// decided purely by which round key the controller feeds in.
module one_round_for_encdec
    import sm4_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [31:0]  rk,
    output logic [127:0] state_out
);

    logic [31:0] x0, x1, x2, x3, t;

    assign {x0, x1, x2, x3} = state_in;
    assign t                = x1 ^ x2 ^ x3 ^ rk;
    assign state_out        = {x1, x2, x3, x0 ^ sm4_l(sm4_tau(t))};

endmodule

// File: rtl/sm4_iter_ctrl.sv
// Iterative SM4 block controller: one round per clock over 32 cycles, with
// an on-chip 32-entry round-key file writable only while idle.
// Optional macro SM4_CTRL_PERF_CNT_EN adds a saturating completed-block
// counter on output port blk_cnt.
module sm4_iter_ctrl #(
    parameter int NUM_ROUNDS = sm4_pkg::NUM_ROUNDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_decrypt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    input  logic         rk_we,
    input  logic [4:0]   rk_addr,
    input  logic [31:0]  rk_wdata,
`ifdef SM4_CTRL_PERF_CNT_EN
    output logic [31:0]  blk_cnt,
`endif
    output logic         busy
);
    import sm4_pkg::*;

    localparam logic [4:0] LAST = 5'(NUM_ROUNDS - 1);

    logic [1:0]   fsm;
    logic [127:0] st;
    logic [127:0] st_nxt;
    logic [4:0]   cnt;
    logic         dec;
    logic [4:0]   rk_idx;
    logic [31:0]  rk_mem [NUM_ROUNDS];

    assign in_ready  = (fsm == ST_IDLE);
    assign out_valid = (fsm == ST_DONE);
    assign busy      = (fsm != ST_IDLE);

    // Final state is X32..X35; the cipher output is those words reversed
    assign out_data = {st[31:0], st[63:32], st[95:64], st[127:96]};

    // Decryption walks the same key file backwards
    assign rk_idx = dec ? (LAST - cnt) : cnt;

    one_round_for_encdec u_round (
        .state_in  (st),
        .rk        (rk_mem[rk_idx]),
        .state_out (st_nxt)
    );

    // Control FSM plus state/counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm <= ST_IDLE;
            st  <= '0;
            cnt <= '0;
            dec <= 1'b0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (in_valid) begin
                        st  <= in_data;
                        dec <= in_decrypt;
                        cnt <= '0;
                        fsm <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    st  <= st_nxt;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST) fsm <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) fsm <= ST_IDLE;
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

    // Round-key file; writes are only honoured while idle so a block in
    // flight always sees a consistent key schedule
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ROUNDS; i++) rk_mem[i] <= '0;
        end else if (rk_we && fsm == ST_IDLE) begin
            rk_mem[rk_addr] <= rk_wdata;
        end
    end

`ifdef SM4_CTRL_PERF_CNT_EN
    // Completed-block counter, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt <= '0;
        end else if (out_valid && out_ready && blk_cnt != 32'hFFFF_FFFF) begin
            blk_cnt <= blk_cnt + 32'd1;
        end
    end
`endif

endmodule
